// File: rtl/usr_pkg.sv
// Shared types and constants for the 4-bit universal shift register link.
package usr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_t;

    localparam logic DIR_LSB_FIRST = 1'b0;
    localparam logic DIR_MSB_FIRST = 1'b1;

endpackage

// File: rtl/usr_rx_4bit_if.sv
// Serial input side and buffered parallel output side of the frame receiver.
interface usr_rx_4bit_if #(parameter int WIDTH = 4);

    logic             ser_in;
    logic             ser_en;
    logic             dir;
    logic             p_ready;
    logic             clr_err;
    logic [WIDTH-1:0] p_out;
    logic             p_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output ser_in, ser_en, dir, p_ready, clr_err,
        input  p_out, p_valid, busy, frame_err, overrun
    );

    modport slave (
        input  ser_in, ser_en, dir, p_ready, clr_err,
        output p_out, p_valid, busy, frame_err, overrun
    );

endinterface

// File: rtl/usr_rx_shift.sv
// WIDTH-bit deserialising shift register with direction select and clear.
module usr_rx_shift
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             bit_in,
    output logic [WIDTH-1:0] q
);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            if (dir == DIR_MSB_FIRST)
                q <= {q[WIDTH-2:0], bit_in};
            else
                q <= {bit_in, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/usr_rx_4bit.sv
// Framed serial receiver: start/data/stop FSM, one-deep holding register,
// framing-error pulse and sticky overrun flag.
module usr_rx_4bit
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    usr_rx_4bit_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_t        state;
    logic [CW-1:0]    cnt;
    logic             dir_q;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] p_out_q;
    logic             p_valid_q;
    logic             frame_err_q;
    logic             overrun_q;

    logic start_hit, bit_hit, stop_hit, commit, take, store, drop;

    assign start_hit = (state == IDLE) && bus.ser_en && !bus.ser_in;
    assign bit_hit   = (state == DATA) && bus.ser_en;
    assign stop_hit  = (state == STOP) && bus.ser_en;
    assign commit    = stop_hit && bus.ser_in;
    assign take      = p_valid_q && bus.p_ready;
    // A full buffer being drained on the commit edge still has room.
    assign store     = commit && (!p_valid_q || bus.p_ready);
    assign drop      = commit && !store;

    usr_rx_shift #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_hit),
        .shift_en (bit_hit),
        .dir      (dir_q),
        .bit_in   (bus.ser_in),
        .q        (sr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            dir_q <= DIR_LSB_FIRST;
        end else begin
            case (state)
                IDLE: if (start_hit) begin
                    dir_q <= bus.dir;
                    cnt   <= '0;
                    state <= DATA;
                end
                DATA: if (bus.ser_en) begin
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= STOP;
                end
                STOP: if (bus.ser_en) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_out_q     <= '0;
            p_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_hit && !bus.ser_in;

            if (store) begin
                p_out_q   <= sr;
                p_valid_q <= 1'b1;
            end else if (take) begin
                p_valid_q <= 1'b0;
            end

            if (drop)
                overrun_q <= 1'b1;
            else if (bus.clr_err)
                overrun_q <= 1'b0;
        end
    end

    assign bus.p_out     = p_out_q;
    assign bus.p_valid   = p_valid_q;
    assign bus.busy      = (state != IDLE);
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule
